depth_test: RTL
===============

Name: depth_test

Overview:
Per-fragment depth test stage directly downstream of the rasterizer's perspective-corrected fragment output. It accepts one fragment at a time and reads the stored depth from a single-port-style z-buffer interface with 1-cycle read latency. It compares the stored depth against the fragment's depth using a programmable function, optionally writes the new depth back, and forwards only passing fragments to the shading/framebuffer stage. It also provides a z-buffer clear sweep.

Parameters:
FB_WIDTH, 640, framebuffer width in pixels
FB_HEIGHT, 480, framebuffer height in pixels
DEPTH_W, 16, stored depth width in bits
ADDR_W, 19, z-buffer address width; must satisfy 2^ADDR_W >= FB_WIDTH*FB_HEIGHT

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
frag_in  in  fragment_t  input fragment; uses fields x, y, z
frag_in_valid  in  1  input handshake valid
frag_in_ready  out  1  input handshake ready
frag_out  out  fragment_t  passing fragment, unmodified copy of the accepted fragment
frag_out_valid  out  1  output handshake valid
frag_out_ready  in  1  output handshake ready
depth_test_en  in  1  0 = bypass test, no z-buffer access
depth_write_en  in  1  1 = write fragment depth on pass
depth_func  in  3  0 NEVER, 1 LESS, 2 EQUAL, 3 LEQUAL, 4 GREATER, 5 NOTEQUAL, 6 GEQUAL, 7 ALWAYS
clear_start  in  1  pulse: begin z-buffer clear
clear_value  in  DEPTH_W  depth written by clear
clear_done  out  1  1-cycle pulse when clear completes
zb_rd_en  out  1  z-buffer read strobe
zb_rd_addr  out  ADDR_W  read address
zb_rd_data  in  DEPTH_W  read data, valid the cycle after zb_rd_en
zb_wr_en  out  1  z-buffer write strobe
zb_wr_addr  out  ADDR_W  write address
zb_wr_data  out  DEPTH_W  write data
frags_passed  out  32  count of fragments emitted
frags_killed  out  32  count of fragments discarded
busy  out  1  state != IDLE

Behaviour:
- Clock is clk; reset is synchronous, active-high. Reset forces IDLE; all strobes (zb_rd_en, zb_wr_en, frag_out_valid, clear_done) are 0; both counters are 0; busy is 0. Reset has effect on the next clk edge even mid-fragment or mid-clear: the in-flight fragment is dropped and a partial clear is abandoned.
- Depth key: key = frag_in.z[31:32-DEPTH_W] (monotonic for non-negative fp32). If z sign bit = 1, key = 0. addr = y*FB_WIDTH + x.
- States: IDLE, READ, CMP, OUT, CLEAR.
- frag_in_ready = (state == IDLE) && !clear_start.
- IDLE, clear_start=1: go to CLEAR, clear address = 0. clear_start has priority over frag_in_valid in the same cycle. clear_start outside IDLE is ignored.
- IDLE, fragment accepted: latch frag, key, addr, depth_func, and depth_write_en. Config is sampled only at accept.
  - If x >= FB_WIDTH or y >= FB_HEIGHT: kill (frags_killed++), stay IDLE.
  - Else if depth_test_en = 0: go to OUT with no read and no write.
  - Else: go to READ.
- READ: zb_rd_en = 1, zb_rd_addr = latched addr, for exactly 1 cycle; go to CMP.
- CMP: evaluate the function with key as the left operand and zb_rd_data as the right operand (e.g. LESS passes when key < stored).
  - Pass: go to OUT; arm a write if depth_write_en was latched as 1.
  - Fail: frags_killed++, go to IDLE.
- OUT: frag_out_valid = 1 and frag_out is held stable until frag_out_ready.
  - If a write is armed: zb_wr_en = 1 in the first OUT cycle only, with wr_addr = addr and wr_data = key.
  - On the handshake: frags_passed++, go to IDLE.
- Minimum latency, accept to frag_out_valid: 3 cycles with the test enabled, 1 cycle with the test disabled. Peak throughput is 1 fragment per 4 cycles; no read-after-write hazard is possible.
- CLEAR: zb_wr_en = 1, wr_addr = counter, wr_data = clear_value (sampled every cycle), one address per cycle, from 0 to FB_WIDTH*FB_HEIGHT-1. After the last write: clear_done = 1 for 1 cycle and go to IDLE. Total duration is exactly FB_WIDTH*FB_HEIGHT cycles.
- Counters saturate at 32'hFFFF_FFFF.
- zb_rd_addr and zb_wr_addr are 0 whenever their strobe is low.

Test Plan:
1. Reset, then LESS with write enabled: send (x=3, y=2, key=0x3000) with stored 0x4000 -> zb_rd_addr = 1283 one cycle after accept; frag_out_valid 3 cycles after accept; zb_wr_en writes 0x3000 to 1283; frags_passed = 1.
2. Same fragment, stored 0x2000 -> no frag_out_valid, no write, frags_killed = 1, frag_in_ready high again the cycle after CMP.
3. Sweep all 8 depth_func values with key = stored = 0x1234 -> pass for EQUAL, LEQUAL, GEQUAL, ALWAYS; kill for NEVER, LESS, GREATER, NOTEQUAL.
4. Out-of-range x = 640 -> immediate kill, zb_rd_en never asserted. depth_test_en = 0 -> pass after 1 cycle, no rd or wr strobes. Hold frag_out_ready low for 5 cycles -> frag_out stable, zb_wr_en high only in the first OUT cycle.
5. Params FB_WIDTH=4, FB_HEIGHT=2: clear_start together with frag_in_valid -> fragment not accepted; 8 writes of clear_value to addresses 0..7; clear_done pulses once; the fragment is then accepted.
6. Assert rst during CLEAR at address 3 and again during OUT -> next cycle IDLE, all strobes 0, counters 0, dropped fragment never appears.

Source files
------------

// File: rtl/depth_test.sv
// depth_test: per-fragment depth test stage with z-buffer clear sweep.
//
// Accepts one fragment at a time. It reads the stored depth over a z-buffer
// port with 1-cycle read latency and compares it against the fragment key
// using depth_func. On a pass it optionally writes the key back and forwards
// the fragment unchanged. It also sweeps the whole z-buffer with clear_value.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   frag_in/_valid/_ready         input fragment handshake
//   frag_out/_valid/_ready        passing-fragment handshake
//   depth_test_en                 0 = bypass, no z-buffer access
//   depth_write_en                write key back on pass
//   depth_func                    NEVER,LESS,EQUAL,LEQUAL,GREATER,NOTEQUAL,GEQUAL,ALWAYS
//   clear_start/value/done        z-buffer clear control
//   zb_rd_*, zb_wr_*              z-buffer read/write ports
//   frags_passed, frags_killed    saturating event counters
//   busy                          high whenever not idle

package depth_test_pkg;
   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic [31:0] z;
   } fragment_t;
endpackage

module depth_test
   import depth_test_pkg::*;
#(
   parameter int unsigned FB_WIDTH  = 640,
   parameter int unsigned FB_HEIGHT = 480,
   parameter int unsigned DEPTH_W   = 16,
   parameter int unsigned ADDR_W    = 19
) (
   input  logic               clk,
   input  logic               rst,
   input  fragment_t          frag_in,
   input  logic               frag_in_valid,
   output logic               frag_in_ready,
   output fragment_t          frag_out,
   output logic               frag_out_valid,
   input  logic               frag_out_ready,
   input  logic               depth_test_en,
   input  logic               depth_write_en,
   input  logic [2:0]         depth_func,
   input  logic               clear_start,
   input  logic [DEPTH_W-1:0] clear_value,
   output logic               clear_done,
   output logic               zb_rd_en,
   output logic [ADDR_W-1:0]  zb_rd_addr,
   input  logic [DEPTH_W-1:0] zb_rd_data,
   output logic               zb_wr_en,
   output logic [ADDR_W-1:0]  zb_wr_addr,
   output logic [DEPTH_W-1:0] zb_wr_data,
   output logic [31:0]        frags_passed,
   output logic [31:0]        frags_killed,
   output logic               busy
);

   typedef enum logic [2:0] {IDLE, READ, CMP, OUT, CLEAR} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

   state_t             state, state_n;
   fragment_t          frag_q;
   logic [DEPTH_W-1:0] key_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [2:0]         func_q;
   logic               we_q;
   logic               wr_armed;
   logic [ADDR_W-1:0]  clr_addr;

   logic [DEPTH_W-1:0] key_in;
   logic [ADDR_W-1:0]  addr_in;
   logic               out_of_range;
   logic               accept;
   logic               cmp_pass;

   // Negative z maps to the nearest depth; for non-negative fp32 the top bits
   // are monotonic in z, so a plain truncation is a valid depth key.
   always_comb begin
      key_in       = frag_in.z[31] ? '0 : frag_in.z[31 -: DEPTH_W];
      addr_in      = ADDR_W'(frag_in.y) * ADDR_W'(FB_WIDTH) + ADDR_W'(frag_in.x);
      out_of_range = ({16'd0, frag_in.x} >= FB_WIDTH) || ({16'd0, frag_in.y} >= FB_HEIGHT);
      accept       = (state == IDLE) && !clear_start && frag_in_valid;
   end

   always_comb begin
      cmp_pass = 1'b0;
      case (func_q)
         3'd0:    cmp_pass = 1'b0;
         3'd1:    cmp_pass = key_q <  zb_rd_data;
         3'd2:    cmp_pass = key_q == zb_rd_data;
         3'd3:    cmp_pass = key_q <= zb_rd_data;
         3'd4:    cmp_pass = key_q >  zb_rd_data;
         3'd5:    cmp_pass = key_q != zb_rd_data;
         3'd6:    cmp_pass = key_q >= zb_rd_data;
         default: cmp_pass = 1'b1;
      endcase
   end

   // State register plus the datapath registers that move with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         wr_armed     <= 1'b0;
         clr_addr     <= '0;
         clear_done   <= 1'b0;
         frags_passed <= '0;
         frags_killed <= '0;
      end else begin
         state      <= state_n;
         clear_done <= (state == CLEAR) && (clr_addr == LAST_ADDR);

         if (accept) begin
            frag_q <= frag_in;
            key_q  <= key_in;
            addr_q <= addr_in;
            func_q <= depth_func;
            we_q   <= depth_write_en;
         end

         if ((state == IDLE) && clear_start)
            clr_addr <= '0;
         else if (state == CLEAR)
            clr_addr <= clr_addr + 1'b1;

         // Write-back is armed by a passing compare and used up by the first OUT cycle.
         if (state == CMP)
            wr_armed <= cmp_pass && we_q;
         else if (state == OUT)
            wr_armed <= 1'b0;

         if (((accept && out_of_range) || ((state == CMP) && !cmp_pass)) &&
             (frags_killed != 32'hFFFF_FFFF))
            frags_killed <= frags_killed + 32'd1;

         if ((state == OUT) && frag_out_ready && (frags_passed != 32'hFFFF_FFFF))
            frags_passed <= frags_passed + 32'd1;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (clear_start)
               state_n = CLEAR;
            else if (frag_in_valid) begin
               if (out_of_range)
                  state_n = IDLE;
               else if (!depth_test_en)
                  state_n = OUT;
               else
                  state_n = READ;
            end
         end
         READ:    state_n = CMP;
         CMP:     state_n = cmp_pass ? OUT : IDLE;
         OUT:     if (frag_out_ready) state_n = IDLE;
         CLEAR:   if (clr_addr == LAST_ADDR) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      frag_in_ready  = (state == IDLE) && !clear_start;
      frag_out       = frag_q;
      frag_out_valid = (state == OUT);
      zb_rd_en       = (state == READ);
      zb_rd_addr     = (state == READ) ? addr_q : '0;
      zb_wr_en       = 1'b0;
      zb_wr_addr     = '0;
      zb_wr_data     = '0;
      busy           = (state != IDLE);
      if (state == CLEAR) begin
         zb_wr_en   = 1'b1;
         zb_wr_addr = clr_addr;
         zb_wr_data = clear_value;
      end else if ((state == OUT) && wr_armed) begin
         zb_wr_en   = 1'b1;
         zb_wr_addr = addr_q;
         zb_wr_data = key_q;
      end
   end

endmodule
